// File: rtl/irq_timer_pkg.sv
// Shared encodings for the irq_timer_bank register interface.
package irq_timer_pkg;

    localparam logic [1:0] WR_SEL_PERIOD   = 2'd0;
    localparam logic [1:0] WR_SEL_CTRL     = 2'd1;
    localparam logic [1:0] WR_SEL_PRESCALE = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_TGL     = 2;
    localparam int CTRL_W       = 3;

endpackage

// File: rtl/irq_timer_chan.sv
// One periodic timer channel: period/ctrl registers, counter, sticky pending,
// one-cycle expiry strobe and toggle output.
module irq_timer_chan
    import irq_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_25mhz,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             wr_period_i,
    input  logic             wr_ctrl_i,
    input  logic [CNT_W-1:0] wr_data_i,
    input  logic             ack_i,
    output logic             pulse_o,
    output logic             pend_o,
    output logic             tgl_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              pulse_q, pend_q, pend_d, tgl_q, tgl_d;
    logic              expire;

    always_comb begin
        // A period write restarts the interval, so it suppresses expiry that cycle.
        expire   = ctrl_q[CTRL_EN] && tick_i && (cnt_q == period_q) && !wr_period_i;
        period_d = wr_period_i ? wr_data_i : period_q;

        ctrl_d = ctrl_q;
        if (wr_ctrl_i)
            ctrl_d = wr_data_i[CTRL_W-1:0];
        else if (expire && ctrl_q[CTRL_ONESHOT])
            ctrl_d[CTRL_EN] = 1'b0;

        cnt_d = cnt_q;
        if (wr_period_i || (wr_ctrl_i && !ctrl_q[CTRL_EN] && wr_data_i[CTRL_EN]))
            cnt_d = '0;
        else if (expire)
            cnt_d = '0;
        else if (ctrl_q[CTRL_EN] && tick_i)
            cnt_d = cnt_q + CNT_W'(1);

        pend_d = expire || (pend_q && !ack_i);
        tgl_d  = tgl_q ^ (expire && ctrl_q[CTRL_TGL]);
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            period_q <= '0;
            ctrl_q   <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            pend_q   <= 1'b0;
            tgl_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            pulse_q  <= expire;
            pend_q   <= pend_d;
            tgl_q    <= tgl_d;
        end
    end

    assign pulse_o = pulse_q;
    assign pend_o  = pend_q;
    assign tgl_o   = tgl_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/irq_timer_bank.sv
// Multi-channel periodic interrupt generator: write decode, shared tick, readback mux.
// Define ITB_PRESCALER_EN to add the shared programmable prescaler (wr_sel=2).
module irq_timer_bank
    import irq_timer_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int CNT_W   = 16,
    parameter  int PRESC_W = 8,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_25mhz,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [1:0]       wr_sel,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [NCH-1:0]   irq_ack,
    output logic [NCH-1:0]   irq_pulse,
    output logic [NCH-1:0]   irq_pend,
    output logic             irq_any,
    output logic [NCH-1:0]   tgl_out,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [CNT_W-1:0] rd_cnt
);

    logic             wr_ok;
    logic             tick;
    logic [CNT_W-1:0] cnt_w [NCH];
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    assign wr_ok = wr_en && (int'(wr_ch) < NCH);

`ifdef ITB_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;

    always_comb begin
        tick    = (pcnt_q == presc_q);
        presc_d = presc_q;
        pcnt_d  = tick ? '0 : pcnt_q + PRESC_W'(1);
        if (wr_ok && wr_sel == WR_SEL_PRESCALE) begin
            presc_d = wr_data[PRESC_W-1:0];
            pcnt_d  = '0;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic hit;
        assign hit = wr_ok && (wr_ch == CH_W'(i));

        irq_timer_chan #(.CNT_W(CNT_W)) u_chan (
            .clk_25mhz   (clk_25mhz),
            .rst         (rst),
            .tick_i      (tick),
            .wr_period_i (hit && (wr_sel == WR_SEL_PERIOD)),
            .wr_ctrl_i   (hit && (wr_sel == WR_SEL_CTRL)),
            .wr_data_i   (wr_data),
            .ack_i       (irq_ack[i]),
            .pulse_o     (irq_pulse[i]),
            .pend_o      (irq_pend[i]),
            .tgl_o       (tgl_out[i]),
            .cnt_o       (cnt_w[i])
        );
    end

    always_comb begin
        rd_cnt_d = '0;
        if (int'(rd_ch) < NCH)
            rd_cnt_d = cnt_w[rd_ch];
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst)
            rd_cnt_q <= '0;
        else
            rd_cnt_q <= rd_cnt_d;
    end

    assign rd_cnt  = rd_cnt_q;
    assign irq_any = |irq_pend;

endmodule
